cordic_sincos: RTL and testbench



---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_atan_rom.sv | 23 ++
 rtl/cordic_sincos.sv | 130 +++++++++++++
 tb/tb_cordic_sincos.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the cordic_sincos trigonometric engine.
// Holds the Q2.16 angle/data format, iteration count, CORDIC gain
// compensation, pi/2 and the per-iteration arctangent table.
package cordic_pkg;

    localparam int ANGLE_W     = 18;
    localparam int FRAC_W      = 16;
    localparam int CORDIC_ITER = 16;

    localparam int ATAN_LEN    = 16;
    localparam int ATAN_IDX_W  = 4;

    // 0.6072529 in Q2.16; pre-scaling x by this cancels the CORDIC gain
    localparam int K_Q16       = 39797;
    // pi/2 in Q2.16, used by the optional quadrant pre-rotation
    localparam int HALF_PI_Q16 = 102944;

    // atan(2^-i) in Q2.16 for i = 0..15
    localparam int ATAN_TABLE [ATAN_LEN] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
        256,   128,   64,    32,   16,   8,    4,    2
    };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of atan(2^-i) for CORDIC iteration i.
// The table value is scaled up by the guard bits so it lines up with the
// widened z datapath; indices past the table end return zero.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int GUARD = 2,
    parameter int OUT_W = ANGLE_W + GUARD
) (
    input  logic [IDX_W-1:0]        i_index,
    output logic signed [OUT_W-1:0] o_atan
);

    // Table read with out-of-range protection
    always_comb begin
        o_atan = '0;
        if (i_index < IDX_W'(ATAN_LEN)) begin
            o_atan = OUT_W'(ATAN_TABLE[i_index[ATAN_IDX_W-1:0]] << GUARD);
        end
    end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC producing cos/sin of a Q2.16 angle.
// One micro-rotation per clock; 'init' is a synchronous reset that also
// loads the angle. Results and 'done' hold until the next 'init'.
// Optional feature: define CORDIC_QUADRANT_EN to pre-rotate angles beyond
// +/-pi/2 at load so the full [-2, 2) input range converges.
module cordic_sincos
    import cordic_pkg::*;
#(
    parameter int ITER  = CORDIC_ITER,
    parameter int GUARD = 2
) (
    input  logic                      clock,
    input  logic                      init,
    input  logic signed [ANGLE_W-1:0] in_angle,
    output logic signed [ANGLE_W-1:0] cos_out,
    output logic signed [ANGLE_W-1:0] sin_out,
    output logic                      done
);

    localparam int DW = ANGLE_W + GUARD;
    localparam int CW = $clog2(ITER + 1);

    localparam logic signed [DW-1:0] K_EXT       = DW'(K_Q16 << GUARD);
    localparam logic signed [DW-1:0] HALF_PI_EXT = DW'(HALF_PI_Q16 << GUARD);

    logic signed [DW-1:0]      r_x;
    logic signed [DW-1:0]      r_y;
    logic signed [DW-1:0]      r_z;
    logic [CW-1:0]             r_count;
    logic signed [ANGLE_W-1:0] r_cos;
    logic signed [ANGLE_W-1:0] r_sin;
    logic                      r_done;

    logic signed [DW-1:0] w_angleExt;
    logic signed [DW-1:0] w_loadX;
    logic signed [DW-1:0] w_loadY;
    logic signed [DW-1:0] w_loadZ;
    logic signed [DW-1:0] w_atan;
    logic signed [DW-1:0] w_xShift;
    logic signed [DW-1:0] w_yShift;
    logic signed [DW-1:0] w_xNext;
    logic signed [DW-1:0] w_yNext;
    logic signed [DW-1:0] w_zNext;
    logic                 w_dPos;
    logic                 w_running;
    logic                 w_lastIter;

    // Drop the guard bits with round-to-nearest, then clamp to the Q2.16 range
    function automatic logic signed [ANGLE_W-1:0] roundSat(input logic signed [DW-1:0] v);
        logic signed [DW:0]      rounded;
        logic signed [ANGLE_W:0] scaled;
        rounded = {v[DW-1], v} + (DW+1)'(1 << (GUARD - 1));
        scaled  = rounded[DW:GUARD];
        if (scaled[ANGLE_W] != scaled[ANGLE_W-1]) begin
            roundSat = scaled[ANGLE_W] ? {1'b1, {(ANGLE_W-1){1'b0}}}
                                       : {1'b0, {(ANGLE_W-1){1'b1}}};
        end else begin
            roundSat = scaled[ANGLE_W-1:0];
        end
    endfunction

    cordic_atan_rom #(
        .IDX_W (CW),
        .GUARD (GUARD),
        .OUT_W (DW)
    ) u_atanRom (
        .i_index (r_count),
        .o_atan  (w_atan)
    );

    assign w_angleExt = {in_angle, {GUARD{1'b0}}};

    // Initial vector and residual angle captured while init is high
    always_comb begin
        w_loadX = K_EXT;
        w_loadY = '0;
        w_loadZ = w_angleExt;
`ifdef CORDIC_QUADRANT_EN
        if (w_angleExt > HALF_PI_EXT) begin
            w_loadX = '0;
            w_loadY = K_EXT;
            w_loadZ = w_angleExt - HALF_PI_EXT;
        end else if (w_angleExt < -HALF_PI_EXT) begin
            w_loadX = '0;
            w_loadY = -K_EXT;
            w_loadZ = w_angleExt + HALF_PI_EXT;
        end
`endif
    end

    // One micro-rotation: direction follows the sign of the residual angle
    always_comb begin
        w_dPos     = ~r_z[DW-1];
        w_xShift   = r_x >>> r_count;
        w_yShift   = r_y >>> r_count;
        w_xNext    = w_dPos ? (r_x - w_yShift) : (r_x + w_yShift);
        w_yNext    = w_dPos ? (r_y + w_xShift) : (r_y - w_xShift);
        w_zNext    = w_dPos ? (r_z - w_atan)   : (r_z + w_atan);
        w_running  = (r_count < CW'(ITER));
        w_lastIter = (r_count == CW'(ITER - 1));
    end

    // Load on init, otherwise iterate until the counter parks at ITER
    always_ff @(posedge clock) begin
        if (init) begin
            r_x     <= w_loadX;
            r_y     <= w_loadY;
            r_z     <= w_loadZ;
            r_count <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
            r_done  <= 1'b0;
        end else if (w_running) begin
            r_x     <= w_xNext;
            r_y     <= w_yNext;
            r_z     <= w_zNext;
            r_count <= r_count + CW'(1);
            if (w_lastIter) begin
                r_cos  <= roundSat(w_xNext);
                r_sin  <= roundSat(w_yNext);
                r_done <= 1'b1;
            end
        end
    end

    assign cos_out = r_cos;
    assign sin_out = r_sin;
    assign done    = r_done;

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: table-driven vectors with a
// scoreboard queue of expected results, plus hand-written sequences for
// latency, abort, held init and idle hold. Honours CORDIC_QUADRANT_EN.
module tb_cordic_sincos;

    localparam int TOL       = 8;
    localparam int MAX_WAIT  = 40;

    typedef struct {
        string             name;
        logic signed [17:0] angle;
        int                expCos;
        int                expSin;
    } vec_t;

    logic               clock;
    logic               init;
    logic signed [17:0] in_angle;
    logic signed [17:0] cos_out;
    logic signed [17:0] sin_out;
    logic               done;

    int   nChecks;
    int   nFail;
    vec_t sbQ[$];
    vec_t vecs[$];
    int   lastCos;
    int   lastSin;

    cordic_sincos dut (
        .clock    (clock),
        .init     (init),
        .in_angle (in_angle),
        .cos_out  (cos_out),
        .sin_out  (sin_out),
        .done     (done)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Backstop so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int toQ16(input real v);
        return int'($floor(v * 65536.0 + 0.5));
    endfunction

    function automatic vec_t modelVec(input string nm, input logic signed [17:0] a);
        vec_t v;
        real  r;
        r        = real'(int'(a)) / 65536.0;
        v.name   = nm;
        v.angle  = a;
        v.expCos = toQ16($cos(r));
        v.expSin = toQ16($sin(r));
        return v;
    endfunction

    task automatic checkEq(input string nm, input int act, input int req);
        nChecks++;
        if (act != req) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic checkTol(input string nm, input int act, input int req);
        int diff;
        nChecks++;
        diff = act - req;
        if (diff < 0) diff = -diff;
        if (diff > TOL) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%0d required=%0d+/-%0d", nm, act, req, TOL);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse init for one edge with the angle, confirm cleared state, queue expectation
    task automatic applyStimulus(input vec_t v);
        init     = 1'b1;
        in_angle = v.angle;
        tick();
        checkEq({v.name, ".loadDone"}, int'(done), 0);
        checkEq({v.name, ".loadCos"}, int'(cos_out), 0);
        checkEq({v.name, ".loadSin"}, int'(sin_out), 0);
        init     = 1'b0;
        in_angle = 18'($urandom);
        sbQ.push_back(v);
    endtask

    // Wait for done within a bound, check latency and the popped expectation
    task automatic checkOutput();
        int   cycles;
        vec_t e;
        cycles = 0;
        while (!done && cycles < MAX_WAIT) begin
            tick();
            cycles++;
        end
        if (sbQ.size() == 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL scoreboard: actual=empty required=entry");
            return;
        end
        e = sbQ.pop_front();
        checkEq({e.name, ".latency"}, cycles, 16);
        checkEq({e.name, ".done"}, int'(done), 1);
        checkTol({e.name, ".cos"}, int'(cos_out), e.expCos);
        checkTol({e.name, ".sin"}, int'(sin_out), e.expSin);
        lastCos = e.expCos;
        lastSin = e.expSin;
    endtask

    initial begin
        vec_t v;
        nChecks  = 0;
        nFail    = 0;
        init     = 1'b1;
        in_angle = '0;

        vecs.push_back('{"pos1p3",    18'sh14CCD,  17531,  63148});
        vecs.push_back('{"neg1p3",    18'sh2B332,  17530, -63148});
        vecs.push_back('{"zero",      18'sd0,      65536,      0});
        vecs.push_back('{"piOver4",   18'sd51472,  46341,  46341});
        vecs.push_back('{"negPiOver4",-18'sd51472, 46341, -46341});
        vecs.push_back('{"nearPos90", 18'sd102000,   944,  65529});
        vecs.push_back('{"nearNeg90",-18'sd102000,   944, -65529});
`ifdef CORDIC_QUADRANT_EN
        vecs.push_back('{"quad1p9",   18'sd124518, -21187,  62017});
        vecs.push_back('{"quadNeg1p9",-18'sd124518,-21187, -62017});
`endif
        for (int k = 0; k < 6; k++) begin
`ifdef CORDIC_QUADRANT_EN
            vecs.push_back(modelVec("rand", 18'($signed($urandom_range(0, 262000)) - 131000)));
`else
            vecs.push_back(modelVec("rand", 18'($signed($urandom_range(0, 200000)) - 100000)));
`endif
        end

        repeat (3) tick();

        $display("[TB] table vectors");
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k]);
            checkOutput();
        end

        $display("[TB] abort mid-computation");
        applyStimulus(modelVec("aborted", 18'sd85197));
        repeat (7) tick();
        v = sbQ.pop_front();
        applyStimulus(vecs[4]);
        checkOutput();

        $display("[TB] init held high");
        init = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_angle = 18'($urandom);
            tick();
            checkEq("holdDone", int'(done), 0);
            checkEq("holdCos", int'(cos_out), 0);
            checkEq("holdSin", int'(sin_out), 0);
        end

        $display("[TB] idle hold after completion");
        applyStimulus(vecs[3]);
        checkOutput();
        for (int k = 0; k < 55; k++) begin
            in_angle = 18'($urandom);
            tick();
            checkEq("idleDone", int'(done), 1);
            checkTol("idleCos", int'(cos_out), lastCos);
            checkTol("idleSin", int'(sin_out), lastSin);
        end

        $display("[TB] done drops on reload");
        applyStimulus(vecs[0]);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
